seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Runtime-programmable serial bit-sequence detector; generalises the fixed-pattern 10010 Mealy/Moore FSMs.
- Pattern up to MAX_LEN bits; overlapping or non-overlapping detection; in_valid qualifier so idle cycles are not consumed as data.
- Sits on a serial input stream (line decoder, sync-word hunt) and emits a one-cycle match pulse to downstream control.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- LEN_W, $clog2(MAX_LEN+1), width of the pattern-length field.
- CNT_W, 8, width of the match counter (optional feature only).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- cfg_load  in  1  latch cfg_pattern/cfg_len this cycle
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
- cfg_len  in  LEN_W  pattern length, legal 1..MAX_LEN
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- cfg_err  out  1  one-cycle pulse when cfg_load carries an illegal cfg_len
- in_valid  in  1  x is a valid stream bit this cycle
- x  in  1  serial data bit
- match  out  1  one-cycle pulse: pattern just completed
- fill  out  LEN_W  number of valid history bits, saturating at the active length

Behaviour:
- Reset (rst=1 at a clock edge): pattern=0, len=0 (detector disabled), overlap=1, history=0, fill=0, match=0, cfg_err=0. rst takes priority over cfg_load and in_valid.
- Config: on cfg_load with 1<=cfg_len<=MAX_LEN, register pattern/len/overlap, clear history and fill, force match=0 next cycle. Illegal cfg_len (0 or >MAX_LEN): configuration unchanged, history untouched, cfg_err=1 for one cycle.
- cfg_load with in_valid in the same cycle: config wins; that x is discarded.
- Data: on an edge with in_valid=1, history <= {history[MAX_LEN-2:0], x}; fill <= min(fill+1, len).
- Match condition (from next-state values): len!=0, next_fill==len, and next_history[len-1:0]==pattern[len-1:0]. Unused high pattern bits are ignored.
- match is registered: high during the cycle after the edge that samples the final pattern bit (Moore-equivalent latency), exactly one cycle per detection.
- Overlap=1: history and fill kept after a match, so a suffix may start the next match.
- Overlap=0: on a match, fill <= 0 in the same edge; the next match requires len fresh valid bits.
- in_valid=0: history, fill unchanged; match=0.
- len==0: match never asserts; the history still shifts.
- rst mid-stream discards partial matches and configuration.

Optional Feature:
- Macro SEQDET_COUNT_EN. When defined, adds output match_count [CNT_W-1:0]: cleared by rst and by a legal cfg_load, +1 on each match pulse, saturating at all-ones (no wrap).
- Without the macro, the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package seqdet_pkg: default MAX_LEN/CNT_W constants, a length-legality function, and a masked-compare function (history, pattern, len -> bit).
- One sub-module, seqdet_cfg_reg: holds the validated configuration and generates cfg_err. Top level holds the history, fill, match and count logic.

Test Plan:
- Config pattern=5'b10010, len=5, overlap=1; stream 1,0,0,1,0,0,1,0 (in_valid=1 throughout) -> match pulses after bit 5 and after bit 8; count=2.
- Same stream with overlap=0 -> single match after bit 5; none after bit 8.
- Pattern 10010 overlap=1; stream 1,0,0,1 then in_valid=0 for 3 cycles, then 0 -> no match during the gap; match one cycle after the final 0.
- cfg_load with cfg_len=0 and then with cfg_len=MAX_LEN+1 -> cfg_err pulses; prior pattern still detects 10010 correctly.
- Assert rst after 1,0,0,1 -> fill=0 and match=0; a following 0 gives no match; detector disabled until reconfigured.
- SEQDET_COUNT_EN with CNT_W=2, pattern len=1 '1', stream of five 1s -> match_count sequence 1,2,3,3,3.

Source files
------------

// File: rtl/seqdet_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
// The match counter is compiled in only when SEQDET_COUNT_EN is defined.
package seqdet_pkg;

  localparam int unsigned MAX_LEN_DEF = 8;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned CMP_W       = 32;

  // A pattern length is usable only if it selects at least one bit and fits the history.
  function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

  // Compare only the low len bits; bits above the active length are don't-care.
  function automatic logic masked_eq(input logic [CMP_W-1:0] hist,
                                     input logic [CMP_W-1:0] pat,
                                     input int unsigned      len);
    logic [CMP_W-1:0] mask;
    mask = (len >= CMP_W) ? '1 : ((CMP_W'(1) << len) - CMP_W'(1));
    return ((hist ^ pat) & mask) == '0;
  endfunction

endpackage

// File: rtl/seqdet_cfg_reg.sv
// Validated configuration register for the sequence detector.
// Latches pattern/length/overlap on a legal load and pulses cfg_err on an illegal one.
module seqdet_cfg_reg
  import seqdet_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic [MAX_LEN-1:0] pattern,
  output logic [LEN_W-1:0]   len,
  output logic               overlap,
  output logic               cfg_err,
  output logic               load_ok_c
);

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic               cfg_err_q, cfg_err_d;

  always_comb begin
    load_ok_c = cfg_load && len_legal(32'(cfg_len), MAX_LEN);
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    cfg_err_d = cfg_load && !load_ok_c;
    if (load_ok_c) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
    end
  end

  // len of zero after reset keeps the detector disabled until the first legal load.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b1;
      cfg_err_q <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign pattern = pattern_q;
  assign len     = len_q;
  assign overlap = overlap_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-sequence detector with registered match pulse.
// Define SEQDET_COUNT_EN to add the saturating match_count output.
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
`ifdef SEQDET_COUNT_EN
  ,
  parameter int unsigned CNT_W   = CNT_W_DEF
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               in_valid,
  input  logic               x,
  output logic               match,
  output logic [LEN_W-1:0]   fill
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0]   match_count
`endif
);

  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;
  logic               load_ok_c;

  seqdet_cfg_reg #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cfg (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .pattern     (pattern),
    .len         (len),
    .overlap     (overlap),
    .cfg_err     (cfg_err),
    .load_ok_c   (load_ok_c)
  );

  logic [MAX_LEN-1:0] history_q, history_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_q, match_d;
  logic               hit_c;
`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0]   count_q, count_d;
`endif

  // Any cfg_load owns the cycle: a same-cycle data bit is dropped even if the load is rejected.
  always_comb begin
    history_d = history_q;
    fill_d    = fill_q;
    match_d   = 1'b0;
    hit_c     = 1'b0;
`ifdef SEQDET_COUNT_EN
    count_d   = count_q;
`endif
    if (load_ok_c) begin
      history_d = '0;
      fill_d    = '0;
`ifdef SEQDET_COUNT_EN
      count_d   = '0;
`endif
    end else if (!cfg_load && in_valid) begin
      history_d = {history_q[MAX_LEN-2:0], x};
      fill_d    = (fill_q < len) ? fill_q + LEN_W'(1) : len;
      hit_c     = (len != '0) && (fill_d == len) &&
                  masked_eq(CMP_W'(history_d), CMP_W'(pattern), 32'(len));
      match_d   = hit_c;
      if (hit_c && !overlap) begin
        fill_d = '0;
      end
`ifdef SEQDET_COUNT_EN
      if (hit_c && (count_q != '1)) begin
        count_d = count_q + CNT_W'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      history_q <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
`ifdef SEQDET_COUNT_EN
      count_q   <= '0;
`endif
    end else begin
      history_q <= history_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
`ifdef SEQDET_COUNT_EN
      count_q   <= count_d;
`endif
    end
  end

  assign match = match_q;
  assign fill  = fill_q;
`ifdef SEQDET_COUNT_EN
  assign match_count = count_q;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios plus random traffic
// checked against a bit-queue reference model. Honours SEQDET_COUNT_EN.
module tb_seq_detector_param;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
`ifdef SEQDET_COUNT_EN
  localparam int unsigned CNT_W   = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
`endif

  logic               clk;
  logic               rst;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cfg_err;
  logic               in_valid;
  logic               x;
  logic               match;
  logic [LEN_W-1:0]   fill;
`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0]   match_count;
`endif

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
`ifdef SEQDET_COUNT_EN
    ,
    .CNT_W   (CNT_W)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_err     (cfg_err),
    .in_valid    (in_valid),
    .x           (x),
    .match       (match),
    .fill        (fill)
`ifdef SEQDET_COUNT_EN
    ,
    .match_count (match_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: configuration plus the raw received bits as a queue.
  bit [31:0] m_pat;
  int        m_len;
  bit        m_ovl;
  bit        m_hist[$];
  int        m_fill;
  int        m_cnt;
  bit        e_match;
  bit        e_err;

  int vectors;
  int miscompares;
  int seen;

  task automatic model(input bit r, input bit ld, input logic [MAX_LEN-1:0] p,
                       input int l, input bit ov, input bit v, input bit xb);
    e_match = 1'b0;
    e_err   = 1'b0;
    if (r) begin
      m_pat = 0; m_len = 0; m_ovl = 1'b1; m_hist.delete(); m_fill = 0; m_cnt = 0;
    end else if (ld) begin
      if (l >= 1 && l <= MAX_LEN) begin
        m_pat = 32'(p); m_len = l; m_ovl = ov; m_hist.delete(); m_fill = 0; m_cnt = 0;
      end else begin
        e_err = 1'b1;
      end
    end else if (v) begin
      m_hist.push_back(xb);
      if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
      if (m_fill < m_len) m_fill++;
      if (m_len > 0 && m_fill == m_len) begin
        e_match = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (m_hist[m_hist.size() - 1 - i] != m_pat[i]) e_match = 1'b0;
      end
      if (e_match) begin
        if (!m_ovl) m_fill = 0;
`ifdef SEQDET_COUNT_EN
        if (m_cnt < CNT_MAX) m_cnt++;
`endif
      end
    end
  endtask

  task automatic step(input bit r, input bit ld, input logic [MAX_LEN-1:0] p,
                      input int l, input bit ov, input bit v, input bit xb);
    @(negedge clk);
    rst = r; cfg_load = ld; cfg_pattern = p; cfg_len = LEN_W'(l);
    cfg_overlap = ov; in_valid = v; x = xb;
    @(posedge clk);
    model(r, ld, p, l, ov, v, xb);
    #1;
    vectors++;
    assert (match === e_match) else begin
      miscompares++;
      $error("FAIL match: got %b want %b at %0t", match, e_match, $time);
    end
    vectors++;
    assert (fill === LEN_W'(m_fill)) else begin
      miscompares++;
      $error("FAIL fill: got %0d want %0d at %0t", fill, m_fill, $time);
    end
    vectors++;
    assert (cfg_err === e_err) else begin
      miscompares++;
      $error("FAIL cfg_err: got %b want %b at %0t", cfg_err, e_err, $time);
    end
`ifdef SEQDET_COUNT_EN
    vectors++;
    assert (match_count === CNT_W'(m_cnt)) else begin
      miscompares++;
      $error("FAIL match_count: got %0d want %0d at %0t", match_count, m_cnt, $time);
    end
`endif
    if (match === 1'b1) seen++;
  endtask

  task automatic do_rst();
    step(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_cfg(input logic [MAX_LEN-1:0] p, input int l, input bit ov);
    step(1'b0, 1'b1, p, l, ov, 1'b0, 1'b0);
  endtask

  task automatic do_bit(input bit b);
    step(1'b0, 1'b0, '0, 0, 1'b0, 1'b1, b);
  endtask

  task automatic do_idle();
    step(1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_seen(input string tag, input int want);
    vectors++;
    assert (seen === want) else begin
      miscompares++;
      $error("FAIL %s: got %0d pulses want %0d", tag, seen, want);
    end
  endtask

  bit [7:0] s10010;

  initial begin
    vectors = 0; miscompares = 0; seen = 0;
    rst = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; in_valid = 1'b0; x = 1'b0;
    s10010 = 8'b1001_0010;

    do_rst();
    do_rst();

    // Overlapping 10010 over 10010010
    do_cfg(8'b0001_0010, 5, 1'b1);
    seen = 0;
    for (int i = 7; i >= 0; i--) do_bit(s10010[i]);
    check_seen("overlap_pulses", 2);

    // Non-overlapping over the same stream
    do_cfg(8'b0001_0010, 5, 1'b0);
    seen = 0;
    for (int i = 7; i >= 0; i--) do_bit(s10010[i]);
    check_seen("nonoverlap_pulses", 1);

    // Idle gap must not consume bits
    do_cfg(8'b0001_0010, 5, 1'b1);
    seen = 0;
    do_bit(1); do_bit(0); do_bit(0); do_bit(1);
    do_idle(); do_idle(); do_idle();
    check_seen("gap_no_match", 0);
    do_bit(0);
    check_seen("gap_match", 1);

    // Illegal lengths are rejected; old pattern survives
    do_cfg(8'hFF, 0, 1'b0);
    do_cfg(8'hFF, MAX_LEN + 1, 1'b0);
    seen = 0;
    do_bit(1); do_bit(0); do_bit(0); do_bit(1); do_bit(0);
    check_seen("illegal_cfg_keeps", 1);

    // Config and data in the same cycle: data is dropped
    step(1'b0, 1'b1, 8'b0000_0011, 2, 1'b1, 1'b1, 1'b1);
    seen = 0;
    do_bit(1);
    check_seen("cfg_wins", 0);
    do_bit(1);
    check_seen("cfg_wins_then", 1);

    // Reset mid-stream disables the detector
    do_cfg(8'b0001_0010, 5, 1'b1);
    do_bit(1); do_bit(0); do_bit(0); do_bit(1);
    do_rst();
    seen = 0;
    do_bit(0);
    do_bit(1); do_bit(0); do_bit(0); do_bit(1); do_bit(0);
    check_seen("rst_disables", 0);

    // Single-bit pattern, counter saturates when enabled
    do_cfg(8'b0000_0001, 1, 1'b1);
    seen = 0;
    for (int i = 0; i < 5; i++) do_bit(1);
    check_seen("len1_pulses", 5);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        do_rst();
      end else if (r < 8) begin
        int l;
        l = ($urandom_range(0, 99) < 70) ? int'($urandom_range(1, 3))
                                         : int'($urandom_range(0, 15));
        step(1'b0, 1'b1, MAX_LEN'($urandom), l, 1'($urandom),
             1'($urandom), 1'($urandom));
      end else begin
        step(1'b0, 1'b0, '0, 0, 1'b0, ($urandom_range(0, 9) < 8), 1'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
